// File: rtl/ysyx_22040759_icache_axi_rd.sv
// Read-only AXI4 bridge below the instruction cache: turns a level-style miss
// request into one single-beat 64-bit AXI4 read and returns the beat to the cache.
module ysyx_22040759_icache_axi_rd #(
    parameter logic [3:0] AXI_ID     = 4'd0,
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icache_ram_ren,
    input  logic [ADDR_WIDTH-1:0] icache_ram_raddr,
    output logic [DATA_WIDTH-1:0] ram_icache_rdata,
    output logic                  icache_data_valid,
    output logic                  icache_bus_err,
    output logic                  ar_valid,
    input  logic                  ar_ready,
    output logic [ADDR_WIDTH-1:0] ar_addr,
    output logic [3:0]            ar_id,
    output logic [7:0]            ar_len,
    output logic [2:0]            ar_size,
    output logic [1:0]            ar_burst,
    input  logic                  r_valid,
    output logic                  r_ready,
    input  logic [DATA_WIDTH-1:0] r_data,
    input  logic [1:0]            r_resp,
    input  logic                  r_last,
    input  logic [3:0]            r_id
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        DONE = 3'd3,
        HOLD = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;

    // Single-beat burst completes on the first beat, so r_last and the
    // sub-word address bits carry no information here.
    logic unused_s;
    assign unused_s = ^{r_last, icache_ram_raddr[2:0]};

    function automatic logic resp_bad(input logic [1:0] resp, input logic [3:0] id);
        return (resp != 2'b00) || (id != AXI_ID);
    endfunction

    // State, address, data and error registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; AXI handshakes are always carried to completion.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (icache_ram_ren) begin
                    addr_d  = {icache_ram_raddr[ADDR_WIDTH-1:3], 3'b000};
                    state_d = AR;
                end else begin
                    state_d = IDLE;
                end
            end
            AR: begin
                if (ar_ready) begin
                    state_d = R;
                end else begin
                    state_d = AR;
                end
            end
            R: begin
                if (r_valid) begin
                    data_d  = r_data;
                    err_d   = resp_bad(r_resp, r_id);
                    state_d = DONE;
                end else begin
                    state_d = R;
                end
            end
            DONE: begin
                state_d = HOLD;
            end
            // A request still high from the cache's final read cycle must not re-issue.
            HOLD: begin
                if (!icache_ram_ren) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ar_valid          = (state_q == AR);
    assign r_ready           = (state_q == R);
    assign icache_data_valid = (state_q == DONE);
    assign icache_bus_err    = (state_q == DONE) && err_q;
    assign ar_addr           = addr_q;
    assign ram_icache_rdata  = data_q;
    assign ar_id             = AXI_ID;
    assign ar_len            = 8'd0;
    assign ar_size           = 3'b011;
    assign ar_burst          = 2'b01;

endmodule

// File: tb/tb_ysyx_22040759_icache_axi_rd.sv
// Directed self-checking bench for the icache AXI read bridge; a small in-bench
// AXI slave applies per-test wait states and response codes.
module tb_ysyx_22040759_icache_axi_rd;

    logic        clk;
    logic        rst;
    logic        icache_ram_ren;
    logic [31:0] icache_ram_raddr;
    logic [63:0] ram_icache_rdata;
    logic        icache_data_valid;
    logic        icache_bus_err;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic [3:0]  ar_id;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid;
    logic        r_ready;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [3:0]  r_id;

    int n_cmp = 0;
    int n_err = 0;

    ysyx_22040759_icache_axi_rd #(
        .AXI_ID(4'd0), .ADDR_WIDTH(32), .DATA_WIDTH(64)
    ) dut (
        .clk(clk), .rst(rst),
        .icache_ram_ren(icache_ram_ren), .icache_ram_raddr(icache_ram_raddr),
        .ram_icache_rdata(ram_icache_rdata), .icache_data_valid(icache_data_valid),
        .icache_bus_err(icache_bus_err),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .r_last(r_last), .r_id(r_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One miss against the in-bench slave over a fixed 40-cycle window.
    // Cycle 1 is the cycle after the edge that samples the request.
    task automatic run_miss(
        input  logic [31:0] addr, input int ar_dly, input int r_dly,
        input  logic [63:0] data, input logic [1:0] resp, input logic [3:0] id,
        input  logic last, input int drop_cyc, input int hold_after,
        output int dv_cyc, output int dv_cnt, output int ar_hs, output int err_cnt,
        output logic err_dv, output logic [63:0] data_dv, output logic [31:0] addr_seen,
        output logic stable, output int held, output int extra_ar);
        int   ar_wait;
        int   r_wait;
        logic seen_ar;
        ar_wait = 0; r_wait = 0; seen_ar = 1'b0;
        dv_cyc = -1; dv_cnt = 0; ar_hs = 0; err_cnt = 0; err_dv = 1'b0;
        data_dv = 64'd0; addr_seen = 32'd0; stable = 1'b1; held = 0; extra_ar = 0;
        icache_ram_raddr = addr;
        icache_ram_ren   = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            step();
            if (cyc == 1) icache_ram_raddr = 32'hFFFF_FFF8;
            if (ar_valid) begin
                if (!seen_ar) begin
                    addr_seen = ar_addr;
                    seen_ar   = 1'b1;
                end else if (ar_addr !== addr_seen) begin
                    stable = 1'b0;
                end
                if (dv_cnt > 0) extra_ar++;
            end else if (seen_ar && ar_hs == 0) begin
                stable = 1'b0;
            end
            if (icache_bus_err) err_cnt++;
            if (icache_data_valid) begin
                dv_cnt++;
                if (dv_cnt == 1) begin
                    dv_cyc  = cyc;
                    err_dv  = icache_bus_err;
                    data_dv = ram_icache_rdata;
                end
            end else if (dv_cnt > 0 && cyc == dv_cyc + 1 + held && ram_icache_rdata === data_dv) begin
                held++;
            end
            if (cyc == drop_cyc) icache_ram_ren = 1'b0;
            if (dv_cnt > 0 && cyc >= dv_cyc + hold_after) icache_ram_ren = 1'b0;
            ar_ready = 1'b0;
            if (ar_valid) begin
                if (ar_wait >= ar_dly) begin
                    ar_ready = 1'b1;
                    ar_hs++;
                end
                ar_wait++;
            end
            r_valid = 1'b0;
            r_data  = ~data;
            r_resp  = 2'b11;
            r_last  = 1'b0;
            r_id    = 4'hF;
            if (r_ready) begin
                if (r_wait >= r_dly) begin
                    r_valid = 1'b1;
                    r_data  = data;
                    r_resp  = resp;
                    r_id    = id;
                    r_last  = last;
                end
                r_wait++;
            end
        end
        icache_ram_ren = 1'b0;
        ar_ready = 1'b0;
        r_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step(); step();
        n_cmp++; if (ar_valid !== 1'b0) begin n_err++; $display("FAIL reset_ar_valid: got %b expected 0", ar_valid); end
        n_cmp++; if (ar_addr !== 32'd0) begin n_err++; $display("FAIL reset_ar_addr: got %h expected 0", ar_addr); end
        n_cmp++; if (r_ready !== 1'b0) begin n_err++; $display("FAIL reset_r_ready: got %b expected 0", r_ready); end
        n_cmp++; if (icache_data_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", icache_data_valid); end
        n_cmp++; if (icache_bus_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", icache_bus_err); end
        n_cmp++; if (ram_icache_rdata !== 64'd0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", ram_icache_rdata); end
        n_cmp++; if (ar_id !== 4'd0 || ar_burst !== 2'b01) begin n_err++; $display("FAIL const_id_burst: got %h/%b expected 0/01", ar_id, ar_burst); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_miss();
        int dv_cyc, dv_cnt, ar_hs, err_cnt, held, extra_ar;
        logic err_dv, stable;
        logic [63:0] data_dv;
        logic [31:0] addr_seen;
        run_miss(32'h8000_0014, 0, 0, 64'h1122_3344_5566_7788, 2'b00, 4'd0, 1'b1, -1, 1,
                 dv_cyc, dv_cnt, ar_hs, err_cnt, err_dv, data_dv, addr_seen, stable, held, extra_ar);
        n_cmp++; if (addr_seen !== 32'h8000_0010) begin n_err++; $display("FAIL single_ar_addr: got %h expected 80000010", addr_seen); end
        n_cmp++; if (ar_len !== 8'd0 || ar_size !== 3'd3) begin n_err++; $display("FAIL single_len_size: got %0d/%0d expected 0/3", ar_len, ar_size); end
        n_cmp++; if (dv_cyc !== 3) begin n_err++; $display("FAIL single_latency: got %0d expected 3", dv_cyc); end
        n_cmp++; if (dv_cnt !== 1) begin n_err++; $display("FAIL single_valid_count: got %0d expected 1", dv_cnt); end
        n_cmp++; if (data_dv !== 64'h1122_3344_5566_7788) begin n_err++; $display("FAIL single_rdata: got %h expected 1122334455667788", data_dv); end
        n_cmp++; if (held < 2) begin n_err++; $display("FAIL single_rdata_held: got %0d cycles expected >=2", held); end
        n_cmp++; if (err_cnt !== 0) begin n_err++; $display("FAIL single_bus_err: got %0d pulses expected 0", err_cnt); end
    endtask

    task automatic test_wait_states();
        int dv_cyc, dv_cnt, ar_hs, err_cnt, held, extra_ar;
        logic err_dv, stable;
        logic [63:0] data_dv;
        logic [31:0] addr_seen;
        // r_last deliberately low: the single beat still completes the request.
        run_miss(32'h0000_1237, 4, 3, 64'hCAFE_F00D_0BAD_BEEF, 2'b00, 4'd0, 1'b0, -1, 1,
                 dv_cyc, dv_cnt, ar_hs, err_cnt, err_dv, data_dv, addr_seen, stable, held, extra_ar);
        n_cmp++; if (stable !== 1'b1 || addr_seen !== 32'h0000_1230) begin n_err++; $display("FAIL wait_ar_stable: got stable=%b addr=%h expected 1/00001230", stable, addr_seen); end
        n_cmp++; if (dv_cyc !== 10) begin n_err++; $display("FAIL wait_latency: got %0d expected 10", dv_cyc); end
        n_cmp++; if (dv_cnt !== 1) begin n_err++; $display("FAIL wait_valid_count: got %0d expected 1", dv_cnt); end
        n_cmp++; if (ar_hs !== 1) begin n_err++; $display("FAIL wait_ar_handshakes: got %0d expected 1", ar_hs); end
        n_cmp++; if (data_dv !== 64'hCAFE_F00D_0BAD_BEEF) begin n_err++; $display("FAIL wait_rdata: got %h expected cafef00d0badbeef", data_dv); end
    endtask

    task automatic test_hold_ren();
        int dv_cyc, dv_cnt, ar_hs, err_cnt, held, extra_ar;
        logic err_dv, stable;
        logic [63:0] data_dv;
        logic [31:0] addr_seen;
        run_miss(32'h8000_0100, 0, 0, 64'h0123_4567_89AB_CDEF, 2'b00, 4'd0, 1'b1, -1, 3,
                 dv_cyc, dv_cnt, ar_hs, err_cnt, err_dv, data_dv, addr_seen, stable, held, extra_ar);
        n_cmp++; if (extra_ar !== 0) begin n_err++; $display("FAIL hold_extra_ar: got %0d expected 0", extra_ar); end
        n_cmp++; if (dv_cnt !== 1) begin n_err++; $display("FAIL hold_valid_count: got %0d expected 1", dv_cnt); end
        run_miss(32'h8000_0108, 0, 0, 64'h0000_0000_0000_0042, 2'b00, 4'd0, 1'b1, -1, 1,
                 dv_cyc, dv_cnt, ar_hs, err_cnt, err_dv, data_dv, addr_seen, stable, held, extra_ar);
        n_cmp++; if (dv_cyc !== 3 || data_dv !== 64'h42) begin n_err++; $display("FAIL back_to_back: got cyc=%0d data=%h expected 3/42", dv_cyc, data_dv); end
    endtask

    task automatic test_bus_err();
        int dv_cyc, dv_cnt, ar_hs, err_cnt, held, extra_ar;
        logic err_dv, stable;
        logic [63:0] data_dv;
        logic [31:0] addr_seen;
        run_miss(32'h8000_0200, 1, 1, 64'h0000_0000_0000_DEAD, 2'b10, 4'd0, 1'b1, -1, 1,
                 dv_cyc, dv_cnt, ar_hs, err_cnt, err_dv, data_dv, addr_seen, stable, held, extra_ar);
        n_cmp++; if (err_dv !== 1'b1 || err_cnt !== 1) begin n_err++; $display("FAIL resp_err: got err=%b pulses=%0d expected 1/1", err_dv, err_cnt); end
        n_cmp++; if (data_dv !== 64'hDEAD) begin n_err++; $display("FAIL resp_err_data: got %h expected dead", data_dv); end
        run_miss(32'h8000_0300, 0, 0, 64'h0000_0000_0000_BEEF, 2'b00, 4'h3, 1'b1, -1, 1,
                 dv_cyc, dv_cnt, ar_hs, err_cnt, err_dv, data_dv, addr_seen, stable, held, extra_ar);
        n_cmp++; if (err_dv !== 1'b1 || err_cnt !== 1 || dv_cnt !== 1) begin n_err++; $display("FAIL id_err: got err=%b pulses=%0d valids=%0d expected 1/1/1", err_dv, err_cnt, dv_cnt); end
    endtask

    task automatic test_reset_in_r();
        int   waited;
        int dv_cyc, dv_cnt, ar_hs, err_cnt, held, extra_ar;
        logic err_dv, stable;
        logic [63:0] data_dv;
        logic [31:0] addr_seen;
        waited = 0;
        icache_ram_raddr = 32'h8000_0400;
        icache_ram_ren   = 1'b1;
        ar_ready = 1'b1;
        step();
        while (!r_ready && waited < 10) begin
            step();
            waited++;
        end
        n_cmp++; if (r_ready !== 1'b1) begin n_err++; $display("FAIL rst_reach_r: got r_ready=%b expected 1 within 10 cycles", r_ready); end
        ar_ready = 1'b0;
        rst = 1'b1; icache_ram_ren = 1'b0;
        r_valid = 1'b1; r_data = 64'h5555_AAAA_5555_AAAA; r_resp = 2'b00; r_id = 4'd0; r_last = 1'b1;
        step();
        n_cmp++; if (r_ready !== 1'b0 || icache_data_valid !== 1'b0 || ar_valid !== 1'b0) begin n_err++; $display("FAIL rst_in_r_ctrl: got r_ready=%b valid=%b ar_valid=%b expected 0/0/0", r_ready, icache_data_valid, ar_valid); end
        n_cmp++; if (ram_icache_rdata !== 64'd0) begin n_err++; $display("FAIL rst_in_r_rdata: got %h expected 0", ram_icache_rdata); end
        rst = 1'b0;
        step();
        n_cmp++; if (r_ready !== 1'b0 || icache_data_valid !== 1'b0) begin n_err++; $display("FAIL stray_beat: got r_ready=%b valid=%b expected 0/0", r_ready, icache_data_valid); end
        r_valid = 1'b0;
        step();
        run_miss(32'h8000_0408, 0, 0, 64'h7777_6666_5555_4444, 2'b00, 4'd0, 1'b1, -1, 1,
                 dv_cyc, dv_cnt, ar_hs, err_cnt, err_dv, data_dv, addr_seen, stable, held, extra_ar);
        n_cmp++; if (dv_cyc !== 3 || dv_cnt !== 1 || data_dv !== 64'h7777_6666_5555_4444) begin n_err++; $display("FAIL rst_recover: got cyc=%0d cnt=%0d data=%h expected 3/1/7777666655554444", dv_cyc, dv_cnt, data_dv); end
    endtask

    task automatic test_ren_drop();
        int dv_cyc, dv_cnt, ar_hs, err_cnt, held, extra_ar;
        logic err_dv, stable;
        logic [63:0] data_dv;
        logic [31:0] addr_seen;
        run_miss(32'h8000_0500, 2, 1, 64'hA5A5_A5A5_5A5A_5A5A, 2'b00, 4'd0, 1'b1, 2, 1,
                 dv_cyc, dv_cnt, ar_hs, err_cnt, err_dv, data_dv, addr_seen, stable, held, extra_ar);
        n_cmp++; if (dv_cnt !== 1 || dv_cyc !== 6) begin n_err++; $display("FAIL drop_complete: got cnt=%0d cyc=%0d expected 1/6", dv_cnt, dv_cyc); end
        n_cmp++; if (ar_hs !== 1 || extra_ar !== 0) begin n_err++; $display("FAIL drop_no_reissue: got hs=%0d extra=%0d expected 1/0", ar_hs, extra_ar); end
        n_cmp++; if (ar_valid !== 1'b0 || r_ready !== 1'b0) begin n_err++; $display("FAIL drop_idle: got ar_valid=%b r_ready=%b expected 0/0", ar_valid, r_ready); end
    endtask

    initial begin
        rst = 1'b1;
        icache_ram_ren = 1'b0; icache_ram_raddr = 32'd0;
        ar_ready = 1'b0; r_valid = 1'b0; r_data = 64'd0;
        r_resp = 2'b00; r_last = 1'b0; r_id = 4'd0;
        test_reset();
        test_single_miss();
        test_wait_states();
        test_hold_ren();
        test_bus_err();
        test_reset_in_r();
        test_ren_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
